// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bundle for the scoreboarded register file.
// master drives w_*, rd_addr, issue_*, clr_req; slave drives rd_data, rd_busy, clr_busy.
interface regfile_sb_if #(
    parameter int WIDTH     = 32,
    parameter int ADD_WIDTH = 5,
    parameter int NUM_RD    = 2
) ();
    logic                        w_en;
    logic [ADD_WIDTH-1:0]        w_reg;
    logic [WIDTH-1:0]            w_data;
    logic [NUM_RD*ADD_WIDTH-1:0] rd_addr;
    logic [NUM_RD*WIDTH-1:0]     rd_data;
    logic [NUM_RD-1:0]           rd_busy;
    logic                        issue_en;
    logic [ADD_WIDTH-1:0]        issue_reg;
    logic                        clr_req;
    logic                        clr_busy;

    modport master (
        output w_en, w_reg, w_data, rd_addr,
        output issue_en, issue_reg, clr_req,
        input  rd_data, rd_busy, clr_busy
    );

    modport slave (
        input  w_en, w_reg, w_data, rd_addr,
        input  issue_en, issue_reg, clr_req,
        output rd_data, rd_busy, clr_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with pending-write scoreboard,
// sequential clear sweep and optional write-to-read bypass (RF_BYPASS_EN).
// Ports: clk, rst_n (async, active-low), bus (regfile_sb_if.slave):
//   w_en/w_reg/w_data writeback, rd_addr/rd_data/rd_busy packed read ports,
//   issue_en/issue_reg scoreboard marking, clr_req/clr_busy clear sweep.
// x0 and addresses >= DEPTH are never stored, read 0 and are never busy.
module regfile_sb #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int ADD_WIDTH = 5,
    parameter int NUM_RD    = 2
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    localparam logic [ADD_WIDTH:0]   DEPTH_W = (ADD_WIDTH + 1)'(DEPTH);
    localparam logic [ADD_WIDTH-1:0] LAST    = ADD_WIDTH'(DEPTH - 1);
    localparam logic [ADD_WIDTH-1:0] FIRST   = ADD_WIDTH'(1);

    if (DEPTH < 2 || DEPTH > (1 << ADD_WIDTH)) begin : g_bad_depth
        $error("regfile_sb: DEPTH out of range");
    end
    if (NUM_RD < 1) begin : g_bad_nrd
        $error("regfile_sb: NUM_RD must be at least 1");
    end

    function automatic logic addr_ok(input logic [ADD_WIDTH-1:0] a);
        return (a != '0) && ({1'b0, a} < DEPTH_W);
    endfunction

    state_t                  state_q;
    state_t                  state_d;
    logic [ADD_WIDTH-1:0]    idx_q;
    logic [ADD_WIDTH-1:0]    idx_d;

    logic [DEPTH-1:1][WIDTH-1:0] mem_q;
    logic [DEPTH-1:1]            sb_q;

    logic idle;
    logic wr_ok;
    logic iss_ok;

    logic [NUM_RD-1:0][ADD_WIDTH-1:0] ra;
    logic [NUM_RD-1:0][WIDTH-1:0]     rdat;
    logic [NUM_RD-1:0]                rbsy;

    assign idle   = (state_q == IDLE);
    assign wr_ok  = idle && bus.w_en && addr_ok(bus.w_reg);
    assign iss_ok = idle && bus.issue_en && addr_ok(bus.issue_reg);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (bus.clr_req) begin
                    state_d = SWEEP;
                    idx_d   = FIRST;
                end
            end
            (state_q == SWEEP): begin
                if (idx_q == LAST) begin
                    state_d = IDLE;
                    idx_d   = FIRST;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= FIRST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Issue is applied after retire so a same-register issue+write leaves
    // the bit set: a newer producer is already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            sb_q  <= '0;
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (!idle) begin
                    if (idx_q == ADD_WIDTH'(r)) begin
                        mem_q[r] <= '0;
                        sb_q[r]  <= 1'b0;
                    end
                end else begin
                    if (wr_ok && bus.w_reg == ADD_WIDTH'(r)) begin
                        mem_q[r] <= bus.w_data;
                        sb_q[r]  <= 1'b0;
                    end
                    if (iss_ok && bus.issue_reg == ADD_WIDTH'(r)) begin
                        sb_q[r] <= 1'b1;
                    end
                end
            end
        end
    end

    assign ra = bus.rd_addr;

    // Only valid indices match, so x0 and out-of-range reads fall to 0.
    always_comb begin
        rdat = '0;
        rbsy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int r = 1; r < DEPTH; r++) begin
                if (ra[i] == ADD_WIDTH'(r)) begin
                    rdat[i] = mem_q[r];
                    rbsy[i] = sb_q[r];
                end
            end
`ifdef RF_BYPASS_EN
            // Held off during reset so outputs show stored (zero) contents.
            if (rst_n && wr_ok && ra[i] == bus.w_reg) begin
                rdat[i] = bus.w_data;
                rbsy[i] = iss_ok && (bus.issue_reg == bus.w_reg);
            end
`endif
        end
    end

    assign bus.rd_data  = rdat;
    assign bus.rd_busy  = rbsy;
    assign bus.clr_busy = (state_q == SWEEP);
endmodule
